imem_resp: RTL and testbench
============================

# imem_resp

Instruction-memory responder for the RISC-V core. It is the fetch-side target of the program counter: it accepts word addresses over a valid/ready request channel and returns the 32-bit instruction at that address over a valid/ready response channel. Read latency is one cycle, with up to two responses outstanding and full one-per-cycle throughput. It also provides a program-load write port and a flush input that discards fetched instructions on a taken branch or jump.

## Interface

Parameters:
- `n`, 32, instruction/data width in bits.
- `alen`, 6, address width. Addresses are word addresses; the PC increments by 1.
- `DEPTH`, 2**alen, number of implemented words. Legal range is 1..2**alen.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  fetch request present.
- `req_addr`  in  alen  word address to fetch.
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at the rising edge.
- `rsp_valid`  out  1  instruction available.
- `rsp_instr`  out  n  instruction word.
- `rsp_err`  out  1  address was out of range (`req_addr >= DEPTH`).
- `rsp_ready`  in  1  consumer takes the response when `rsp_valid && rsp_ready`.
- `flush`  in  1  discard all outstanding and in-flight responses.
- `ld_en`  in  1  program-load write strobe.
- `ld_addr`  in  alen  load word address.
- `ld_data`  in  n  load data.

## Operation

- Storage is a `DEPTH` x `n` array with synchronous read. It is not cleared by reset.
- Loads:
  - When `ld_en=1` and `ld_addr < DEPTH`, `mem[ld_addr]` is written with `ld_data`.
  - When `ld_en=1` and `ld_addr >= DEPTH`, the write is ignored.
  - `ld_en=1` forces `req_ready=0`, so a read and a write never occur in the same cycle.
- Occupancy counting:
  - `occ` is the number of accepted requests whose response has not yet been popped or flushed (in-flight plus buffered). Range 0..2.
  - `pop = rsp_valid && rsp_ready`.
- Request acceptance: `req_ready = reset && !ld_en && (occ - pop < 2)`. This is a combinational path from `rsp_ready` to `req_ready`, and it is permitted.
- Response content:
  - In-range address: `rsp_instr = mem[addr]`, `rsp_err = 0`.
  - Out-of-range address: `rsp_instr = 32'h00000013` (NOP), `rsp_err = 1`.
- Ordering: responses are strictly in request order.
- Response stability: while `rsp_valid=1` and `rsp_ready=0`, `rsp_instr` and `rsp_err` hold stable.
- Flush:
  - `flush=1` at an edge empties all buffered and in-flight responses, and sets `occ` to 0 before any acceptance in that cycle is counted.
  - The response presented in the flush cycle is treated as not popped, even if `rsp_ready=1`.
  - A request accepted in the same cycle as `flush` is kept; it is the redirected target. `req_ready` in the flush cycle is evaluated normally, with `occ`.
  - After the edge, `occ` equals 1 if a request was accepted that cycle, otherwise 0.
- Reset (`reset=0` at an edge):
  - `occ`, `rsp_valid`, `rsp_err` and `rsp_instr` go to 0.
  - `req_ready=0` while `reset=0`.
  - Memory contents are retained.
  - Reset mid-stream discards everything outstanding; no stale response appears after reset is released.
- Structure: read register plus one skid entry (capacity 2). The output is muxed from the skid entry when it is occupied, otherwise from the read register.

## Timing

- Request accepted at edge t: `rsp_valid=1` in the cycle after edge t, with data, unless a flush or reset occurs at edge t+1 or earlier.
- With `rsp_ready` held at 1: one request is accepted per cycle and one response is returned per cycle. `req_ready` stays 1 and `occ` stays at 1.
- With `rsp_ready=0`: two requests are accepted, then `req_ready=0`. The first `rsp_ready=1` cycle re-enables `req_ready` in that same cycle.
- Reset values: `rsp_valid=0`, `rsp_instr=0`, `rsp_err=0`, `req_ready=0`.
- First possible acceptance: `req_ready` may be 1 in the first cycle with `reset=1`.
- A load written at edge t is visible to a request accepted at edge t+1.

## Test plan

- **Load and stream.** Load `mem[0..3]` = `00500093`, `00a00113`, `002081b3`, `00000013`. Then request addresses 0,1,2,3 on consecutive cycles with `rsp_ready=1`. Required: the four words appear on consecutive cycles starting 1 cycle after the first accept, `rsp_err=0`, and `req_ready` never drops.
- **Backpressure.** With `rsp_ready=0`, request addresses 0,1,2. Required: 0 and 1 are accepted, then `req_ready=0` while 2 waits and `rsp_instr=00500093` holds stable. Raise `rsp_ready`: outputs are `00500093`, `00a00113`, `002081b3` in order.
- **Flush.** With two responses outstanding (addresses 1,2, `rsp_ready=0`), assert `flush` while requesting address 3. Required: the next response is `00000013` from address 3 only; the address 1 and 2 responses never appear.
- **Out of range.** With `DEPTH=48`, request address 50. Required: `rsp_instr=00000013`, `rsp_err=1`. A load to address 50 leaves `mem` unchanged.
- **Load priority.** With `ld_en=1` and `req_valid=1` in the same cycle, `req_ready=0`. Load address 2 with `deadbeef`, then request address 2 on the next cycle. Required: response is `deadbeef`.
- **Reset mid-operation.** Drive `reset=0` with two responses outstanding. Required: `rsp_valid=0` and `req_ready=0` during reset, and no stale response afterwards. After release, a request to address 1 returns `00a00113`, showing memory was retained.

Source files
------------

// File: rtl/imem_resp_if.sv
// Fetch-side bundle for imem_resp: request/response handshakes, flush and program-load port.
// The master is the core (fetch unit / loader); the slave is the instruction memory.
interface imem_resp_if #(
    parameter int n    = 32,
    parameter int alen = 6
);
    logic            req_valid;
    logic [alen-1:0] req_addr;
    logic            req_ready;
    logic            rsp_valid;
    logic [n-1:0]    rsp_instr;
    logic            rsp_err;
    logic            rsp_ready;
    logic            flush;
    logic            ld_en;
    logic [alen-1:0] ld_addr;
    logic [n-1:0]    ld_data;

    modport master (
        output req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_instr, rsp_err
    );
endinterface

// File: rtl/imem_resp.sv
// Instruction-memory responder: one-cycle synchronous read, read register plus one skid
// entry so two responses can be outstanding while sustaining one fetch per cycle.
module imem_resp #(
    parameter int n     = 32,
    parameter int alen  = 6,
    parameter int DEPTH = 2 ** alen
) (
    input  logic        i_clock,
    input  logic        i_reset,
    imem_resp_if.slave  bus
);
    localparam int            AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [alen:0] LIM = (alen + 1)'(DEPTH);
    localparam logic [n-1:0]  NOP = n'(32'h0000_0013);

    logic [n-1:0] r_mem [DEPTH];

    logic         r_vld_p1;
    logic [n-1:0] r_dat_p1;
    logic         r_err_p1;
    logic         r_sk_vld;
    logic [n-1:0] r_sk_dat;
    logic         r_sk_err;

    logic          w_req_in;
    logic          w_ld_in;
    logic          w_pop;
    logic          w_accept;
    logic          w_rd_keep;
    logic [AW-1:0] w_req_idx;
    logic [AW-1:0] w_ld_idx;

    assign w_req_in  = {1'b0, bus.req_addr} < LIM;
    assign w_ld_in   = {1'b0, bus.ld_addr} < LIM;
    assign w_req_idx = bus.req_addr[AW-1:0];
    assign w_ld_idx  = bus.ld_addr[AW-1:0];

    // The skid entry is only ever occupied alongside the read register, so occ == 2 iff r_sk_vld.
    assign w_pop         = bus.rsp_valid & bus.rsp_ready;
    assign bus.req_ready = i_reset & ~bus.ld_en & ~(r_sk_vld & ~w_pop);
    assign w_accept      = bus.req_valid & bus.req_ready;
    assign w_rd_keep     = r_vld_p1 & ~(w_pop & ~r_sk_vld);

    assign bus.rsp_valid = r_sk_vld | r_vld_p1;
    assign bus.rsp_instr = r_sk_vld ? r_sk_dat : r_dat_p1;
    assign bus.rsp_err   = r_sk_vld ? r_sk_err : r_err_p1;

    always_ff @(posedge i_clock) begin
        if (bus.ld_en && w_ld_in) begin
            r_mem[w_ld_idx] <= bus.ld_data;
        end
    end

    // Stage p1: read register and skid; an unpopped read-register entry moves to the skid on accept.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_vld_p1 <= 1'b0;
            r_dat_p1 <= '0;
            r_err_p1 <= 1'b0;
            r_sk_vld <= 1'b0;
            r_sk_dat <= '0;
            r_sk_err <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_vld_p1 <= w_accept;
                r_sk_vld <= 1'b0;
            end else begin
                r_vld_p1 <= w_accept | w_rd_keep;
                r_sk_vld <= w_accept ? w_rd_keep : (r_sk_vld & ~w_pop);
            end
            if (w_accept && w_rd_keep && !bus.flush) begin
                r_sk_dat <= r_dat_p1;
                r_sk_err <= r_err_p1;
            end
            if (w_accept) begin
                r_err_p1 <= ~w_req_in;
                r_dat_p1 <= w_req_in ? r_mem[w_req_idx] : NOP;
            end
        end
    end
endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp: a queue scoreboard predicts responses and req_ready each cycle.
module tb_imem_resp;
    localparam int DEPTH = 48;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [31:0] mm [DEPTH];
    logic [32:0] q [$];

    imem_resp_if #(.n(32), .alen(6)) bus ();

    imem_resp #(.n(32), .alen(6), .DEPTH(DEPTH)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] expect_of(input logic [5:0] a);
        if (a < DEPTH) return {1'b0, mm[a]};
        return {1'b1, 32'h0000_0013};
    endfunction

    // One clock: check outputs at the falling edge, advance the model, return just after the rising edge.
    task automatic cyc();
        logic [32:0] front;
        bit ev, pop, er;
        @(negedge clk);
        ev = (q.size() > 0);
        chk("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, ev});
        if (ev) begin
            front = q[0];
            chk("rsp_instr", {32'd0, bus.rsp_instr}, {32'd0, front[31:0]});
            chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, front[32]});
        end
        pop = ev && bus.rsp_ready;
        er  = rst_n && !bus.ld_en && !(q.size() == 2 && !pop);
        chk("req_ready", {63'd0, bus.req_ready}, {63'd0, er});
        if (!rst_n) begin
            q.delete();
        end else begin
            if (bus.flush) q.delete();
            else if (pop) void'(q.pop_front());
            if (er && bus.req_valid) q.push_back(expect_of(bus.req_addr));
        end
        if (bus.ld_en && bus.ld_addr < DEPTH) mm[bus.ld_addr] = bus.ld_data;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        cyc();
        bus.ld_en   = 1'b0;
    endtask

    task automatic req(input logic [5:0] a);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        cyc();
        bus.req_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        bus.flush     = 1'b0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;

        // Reset state: requests refused, outputs cleared.
        idle(2);
        chk("rst_instr", {32'd0, bus.rsp_instr}, 64'd0);
        chk("rst_err", {63'd0, bus.rsp_err}, 64'd0);
        chk("rst_valid", {63'd0, bus.rsp_valid}, 64'd0);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;

        // Program load, including an ignored out-of-range write and the last legal word.
        load(6'd0, 32'h0050_0093);
        load(6'd1, 32'h00a0_0113);
        load(6'd2, 32'h0020_81b3);
        load(6'd3, 32'h0000_0013);
        load(6'd47, 32'h1234_5678);
        load(6'd50, 32'hffff_ffff);

        // Stream with rsp_ready held high.
        bus.rsp_ready = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 6'(a);
            cyc();
            chk("stream_occ1_ready", {63'd0, bus.req_ready}, 64'd1);
        end
        bus.req_valid = 1'b0;
        idle(2);

        // Backpressure: two accepted, third waits, then drains in order.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd0; cyc();
        bus.req_addr  = 6'd1; cyc();
        bus.req_addr  = 6'd2; cyc();
        chk("bp_hold_instr", {32'd0, bus.rsp_instr}, {32'd0, 32'h0050_0093});
        cyc();
        bus.rsp_ready = 1'b1;
        cyc();
        bus.req_valid = 1'b0;
        idle(4);

        // Flush with two outstanding; address 3 is the redirect target.
        bus.rsp_ready = 1'b0;
        req(6'd1);
        req(6'd2);
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd3;
        cyc();
        bus.flush = 1'b0;
        cyc();
        bus.req_valid = 1'b0;
        cyc();
        bus.rsp_ready = 1'b1;
        idle(2);

        // Flush while popping: the presented response is dropped, the same-cycle request kept.
        req(6'd1);
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd0;
        cyc();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        idle(2);

        // Out of range and the last implemented word.
        req(6'd50);
        chk("oor_err", {63'd0, bus.rsp_err}, 64'd1);
        chk("oor_instr", {32'd0, bus.rsp_instr}, {32'd0, 32'h0000_0013});
        req(6'd63);
        req(6'd47);
        idle(2);

        // Load priority over a simultaneous request, then read-after-load.
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd2;
        load(6'd2, 32'hdead_beef);
        cyc();
        bus.req_valid = 1'b0;
        chk("ld_then_read", {32'd0, bus.rsp_instr}, {32'd0, 32'hdead_beef});
        idle(2);

        // Reset with two responses outstanding; memory survives.
        bus.rsp_ready = 1'b0;
        req(6'd0);
        req(6'd3);
        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd1;
        idle(2);
        chk("midrst_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("midrst_instr", {32'd0, bus.rsp_instr}, 64'd0);
        bus.req_valid = 1'b0;
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        idle(2);
        req(6'd1);
        chk("post_rst_read", {32'd0, bus.rsp_instr}, {32'd0, 32'h00a0_0113});
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
